// File: rtl/cpu_ctrl_if.sv
// Bus between the sequencer and its instruction memory, decoder and ALU.
// The controller uses the master modport; the surrounding system uses slave.
interface cpu_ctrl_if #(
  parameter int PC_W = 4
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic            imem_re;
  logic [7:0]      imem_rdata;
  logic [3:0]      opcode;
  logic [3:0]      operand;
  logic            dec_en;
  logic [1:0]      update_flags;
  logic [3:0]      alu_flags;
  logic [3:0]      flags;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;

  modport master (
    input  start, imem_rdata, update_flags, alu_flags,
    output imem_addr, imem_re, opcode, operand, dec_en, flags, pc, busy, halted
  );

  modport slave (
    output start, imem_rdata, update_flags, alu_flags,
    input  imem_addr, imem_re, opcode, operand, dec_en, flags, pc, busy, halted
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer: three cycles per instruction.
// Keeps the program counter, the instruction register and the {N,Z,C,V} flags.
module cpu_ctrl #(
  parameter int PC_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  cpu_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [3:0]      flags_q, flags_d;
  logic [7:0]      ir_q, ir_d;
  logic            imem_re_o, dec_en_o;

  // Branch condition select on opcode[2:0]; 111 never reaches here (halt).
  function automatic logic branch_cond(input logic [2:0] cc, input logic [3:0] f);
    case (cc)
      3'b000:  branch_cond = 1'b1;
      3'b001:  branch_cond = f[2];
      3'b010:  branch_cond = ~f[2];
      3'b011:  branch_cond = f[1];
      3'b100:  branch_cond = f[3];
      3'b101:  branch_cond = f[0];
      3'b110:  branch_cond = ~f[1];
      default: branch_cond = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    ir_d      = ir_q;
    imem_re_o = 1'b0;
    dec_en_o  = 1'b0;
    pc_inc    = pc_q + PC_W'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_re_o = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = bus.imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q[7:4] == 4'hF) begin
          state_d = S_HALT;
        end else if (ir_q[7]) begin
          pc_d    = branch_cond(ir_q[6:4], flags_q) ? PC_W'(ir_q[3:0]) : pc_inc;
          state_d = S_FETCH;
        end else begin
          dec_en_o = 1'b1;
          if (bus.update_flags[1]) flags_d[3:2] = bus.alu_flags[3:2];
          if (bus.update_flags[0]) flags_d[1:0] = bus.alu_flags[1:0];
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_re   = imem_re_o;
  assign bus.dec_en    = dec_en_o;
  assign bus.opcode    = ir_q[7:4];
  assign bus.operand   = ir_q[3:0];
  assign bus.flags     = flags_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign bus.halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: instruction table run back to back through a scoreboard,
// then halt/restart and reset-during-branch sequences.
module tb_cpu_ctrl;
  localparam int PC_W = 4;

  logic clk;
  logic rst_n;
  logic [7:0] cur_instr;

  cpu_ctrl_if #(.PC_W(PC_W)) bus ();

  cpu_ctrl #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] instr;
    logic [3:0] alu;
    logic [1:0] upd;
    logic       dec;
    logic [3:0] pc_after;
    logic [3:0] fl_after;
  } vec_t;

  typedef struct {
    logic [3:0] pc;
    logic [3:0] fl;
  } exp_t;

  vec_t vecs[22];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: returns the current instruction the cycle after a read.
  always @(posedge clk) begin
    if (bus.imem_re) bus.imem_rdata <= cur_instr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fetch(output int waited);
    waited = 0;
    while (bus.imem_re !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (bus.imem_re !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: imem_re never rose within %0d cycles", waited);
    end
  endtask

  initial begin
    int         w;
    logic [3:0] exp_fetch;
    exp_t       e;

    // {instr, alu_flags, update_flags, dec_en, pc after, flags after}; flags = {N,Z,C,V}
    vecs[0]  = '{8'h05, 4'b0100, 2'b11, 1'b1, 4'd1,  4'b0100};
    vecs[1]  = '{8'h97, 4'b1111, 2'b11, 1'b0, 4'd7,  4'b0100};
    vecs[2]  = '{8'h10, 4'b0001, 2'b11, 1'b1, 4'd8,  4'b0001};
    vecs[3]  = '{8'h97, 4'b0100, 2'b11, 1'b0, 4'd9,  4'b0001};
    vecs[4]  = '{8'h20, 4'b1011, 2'b10, 1'b1, 4'd10, 4'b1001};
    vecs[5]  = '{8'h30, 4'b0110, 2'b01, 1'b1, 4'd11, 4'b1010};
    vecs[6]  = '{8'h40, 4'b1111, 2'b00, 1'b1, 4'd12, 4'b1010};
    vecs[7]  = '{8'hA3, 4'b1111, 2'b11, 1'b0, 4'd3,  4'b1010};
    vecs[8]  = '{8'hB5, 4'b1111, 2'b11, 1'b0, 4'd5,  4'b1010};
    vecs[9]  = '{8'hC9, 4'b1111, 2'b11, 1'b0, 4'd9,  4'b1010};
    vecs[10] = '{8'hD2, 4'b1111, 2'b11, 1'b0, 4'd10, 4'b1010};
    vecs[11] = '{8'hE4, 4'b1111, 2'b11, 1'b0, 4'd11, 4'b1010};
    vecs[12] = '{8'h8F, 4'b0000, 2'b11, 1'b0, 4'd15, 4'b1010};
    vecs[13] = '{8'h70, 4'b1111, 2'b00, 1'b1, 4'd0,  4'b1010};
    vecs[14] = '{8'h50, 4'b0000, 2'b11, 1'b1, 4'd1,  4'b0000};
    vecs[15] = '{8'hE6, 4'b1111, 2'b11, 1'b0, 4'd6,  4'b0000};
    vecs[16] = '{8'hD2, 4'b1111, 2'b11, 1'b0, 4'd7,  4'b0000};
    vecs[17] = '{8'h60, 4'b0001, 2'b01, 1'b1, 4'd8,  4'b0001};
    vecs[18] = '{8'hD2, 4'b1111, 2'b11, 1'b0, 4'd2,  4'b0001};
    vecs[19] = '{8'h91, 4'b1111, 2'b11, 1'b0, 4'd3,  4'b0001};
    vecs[20] = '{8'hC4, 4'b1111, 2'b11, 1'b0, 4'd4,  4'b0001};
    vecs[21] = '{8'hB4, 4'b1111, 2'b11, 1'b0, 4'd5,  4'b0001};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.alu_flags    = 4'b0000;
    bus.update_flags = 2'b00;
    cur_instr        = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc",      32'(bus.pc), 32'd0);
    check("rst_flags",   32'(bus.flags), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_halted",  32'(bus.halted), 32'd0);
    check("rst_imem_re", 32'(bus.imem_re), 32'd0);
    check("rst_dec_en",  32'(bus.dec_en), 32'd0);
    check("rst_ir",      32'({bus.opcode, bus.operand}), 32'h00);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", 32'(bus.busy), 32'd0);

    // start stays high through the table; it must be ignored while busy
    bus.start = 1'b1;
    exp_fetch = 4'd0;
    for (int i = 0; i < 22; i++) begin
      wait_fetch(w);
      check($sformatf("v%0d_fetch_gap", i), 32'(w), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_fetch_addr", i), 32'(bus.imem_addr), 32'(exp_fetch));
      cur_instr        = vecs[i].instr;
      bus.alu_flags    = vecs[i].alu;
      bus.update_flags = vecs[i].upd;
      sbq.push_back('{vecs[i].pc_after, vecs[i].fl_after});
      @(negedge clk);
      check($sformatf("v%0d_decode_re", i), 32'({bus.imem_re, bus.busy, bus.dec_en}), 32'b010);
      @(negedge clk);
      check($sformatf("v%0d_exec_dec_en", i), 32'(bus.dec_en), 32'(vecs[i].dec));
      check($sformatf("v%0d_opcode", i), 32'({bus.opcode, bus.operand}), 32'(vecs[i].instr));
      @(negedge clk);
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL v%0d_scoreboard: queue empty", i);
      end else begin
        e = sbq.pop_front();
        check($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(e.pc));
        check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(e.fl));
      end
      exp_fetch = vecs[i].pc_after;
    end

    // Halt at pc=5 with flags 0001, then restart from HALT
    bus.start = 1'b0;
    cur_instr = 8'hF0;
    @(negedge clk);
    @(negedge clk);
    check("halt_exec_dec_en", 32'(bus.dec_en), 32'd0);
    @(negedge clk);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_busy",   32'(bus.busy), 32'd0);
    check("halt_pc",     32'(bus.pc), 32'd5);
    check("halt_re",     32'(bus.imem_re), 32'd0);
    repeat (2) @(negedge clk);
    check("halt_hold", 32'({bus.halted, bus.pc}), 32'h15);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_fetch", 32'({bus.imem_re, bus.busy, bus.halted}), 32'b110);
    check("restart_pc",    32'(bus.pc), 32'd0);
    check("restart_addr",  32'(bus.imem_addr), 32'd0);
    check("restart_flags", 32'(bus.flags), 32'b0001);

    // Reset during EXEC of a taken branch
    cur_instr        = 8'h8C;
    bus.alu_flags    = 4'b1111;
    bus.update_flags = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("rbr_opcode", 32'(bus.opcode), 32'h8);
    rst_n = 1'b0;
    @(negedge clk);
    check("rbr_pc",     32'(bus.pc), 32'd0);
    check("rbr_flags",  32'(bus.flags), 32'd0);
    check("rbr_state",  32'({bus.busy, bus.halted, bus.imem_re, bus.dec_en}), 32'd0);
    check("rbr_ir",     32'({bus.opcode, bus.operand}), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rbr_idle", 32'({bus.busy, bus.imem_re, bus.pc}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 4, giving the program counter and instruction-memory address width (minimum 4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a level that begins program execution from IDLE or HALT.
REQ-005 The block SHALL have port imem_addr, output, PC_W, the instruction-memory read address.
REQ-006 The block SHALL have port imem_re, output, 1, the instruction-memory read strobe.
REQ-007 The block SHALL have port imem_rdata, input, 8, the instruction byte, valid one cycle after imem_re; [7:4] is the opcode and [3:0] the operand.
REQ-008 The block SHALL have port opcode, output, 4, the latched instruction [7:4] driven to the decoder.
REQ-009 The block SHALL have port operand, output, 4, the latched instruction [3:0] driven to the datapath as immediate or register index.
REQ-010 The block SHALL have port dec_en, output, 1, the decoder enable, high only in EXEC for execute-class opcodes.
REQ-011 The block SHALL have port update_flags, input, 2, the decoder flag-update mask: [1] updates N and Z, [0] updates C and V.
REQ-012 The block SHALL have port alu_flags, input, 4, the ALU result flags {N,Z,C,V}.
REQ-013 The block SHALL have port flags, output, 4, the registered {N,Z,C,V}.
REQ-014 The block SHALL have port pc, output, PC_W, the current program counter.
REQ-015 The block SHALL have port busy, output, 1, high in FETCH, DECODE and EXEC.
REQ-016 The block SHALL have port halted, output, 1, high in HALT.

Function
REQ-017 The block SHALL implement FSM states IDLE, FETCH, DECODE, EXEC and HALT, one cycle each except IDLE and HALT.
REQ-018 IDLE SHALL go to FETCH when start=1 and remain in IDLE otherwise.
REQ-019 FETCH SHALL assert imem_re=1 with imem_addr=pc, then go to DECODE.
REQ-020 DECODE SHALL latch imem_rdata into the instruction register (opcode, operand), then go to EXEC.
REQ-021 In EXEC with opcode[3]=0, dec_en SHALL be 1, flag bits selected by update_flags SHALL load from alu_flags at the EXEC clock edge, unselected flag bits SHALL hold, pc SHALL become pc+1, and the next state SHALL be FETCH.
REQ-022 In EXEC with opcode[3]=1 (branch), dec_en SHALL be 0 and flags SHALL hold regardless of update_flags.
REQ-023 Branch conditions by opcode[2:0] SHALL be: 000 always; 001 Z=1; 010 Z=0; 011 C=1; 100 N=1; 101 V=1; 110 C=0.
REQ-024 A taken branch SHALL load pc with the operand zero-extended to PC_W; a not-taken branch SHALL load pc+1; either SHALL go to FETCH.
REQ-025 Opcode 1111 SHALL go to HALT with pc unchanged.
REQ-026 pc+1 SHALL wrap modulo 2^PC_W (all-ones goes to 0) with no error indication.
REQ-027 In HALT, start=1 SHALL clear pc to 0 and go to FETCH; flags SHALL be retained.
REQ-028 In IDLE, HALT, FETCH and DECODE, dec_en SHALL be 0; imem_re SHALL be 1 only in FETCH.
REQ-029 The start input SHALL be ignored while busy=1.
REQ-030 Throughput SHALL be one instruction per 3 cycles.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL enter IDLE, set pc=0, flags=0000 and the instruction register to 0x00, and drive imem_re=0, dec_en=0, busy=0 and halted=0.
REQ-032 rst_n=0 SHALL override start and take priority in every state, including mid-instruction, where the pending pc or flags update SHALL be discarded.

Verification
REQ-033 Reset then start=1 with imem[0]=0x05 (ADD), alu_flags=0100, update_flags=11 -> imem_re at cycle 1, dec_en at cycle 3, flags=0100, pc=1.
REQ-034 With Z=1, BEQ 0x97 -> pc=7; with Z=0, the same instruction -> pc=pc+1, and flags are unchanged in both cases.
REQ-035 An AND with update_flags=10, alu_flags=1011, prior flags=0001 -> flags=1001.
REQ-036 pc=2^PC_W-1 executing a NOP (0x70) -> pc wraps to 0.
REQ-037 0xF0 -> halted=1, busy=0, pc held; then start=1 -> pc=0 and FETCH on the next cycle.
REQ-038 rst_n=0 asserted in EXEC of a taken branch -> next cycle IDLE, pc=0, flags=0000, no branch effect.
